pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised successor to the combinational next-PC selector for the RV32I multicycle core. It owns the architectural PC register and the OLD_PC register, and selects the next PC from sequential, branch, JAL, JALR, trap-vector and return-address sources. It checks every non-sequential target for misalignment and, on a fault, redirects to the trap vector and holds an exception flag until the controller acknowledges it. It sits between the control FSM (which drives pc_write and pcsrc) and the instruction-fetch address path.

Parameters:
XLEN, 32, datapath and PC width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on a trap or misaligned-target fault; must satisfy IALIGN
IALIGN, 32, instruction alignment in bits; legal values 32 or 16

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
pc_write  in  1  PC update strobe from the control FSM
pcsrc  in  3  000 seq, 001 branch, 010 jal, 011 jalr, 100 trap, 101 return (epc); 110/111 reserved
branch_taken  in  1  branch condition result, sampled only when pcsrc=001
branch_target  in  XLEN  PC+imm for branch and jal
alu_output  in  XLEN  rs1+imm for jalr
epc_in  in  XLEN  return address for pcsrc=101
exc_ack  in  1  controller acknowledge; clears exc_pending
pc  out  XLEN  current PC (registered)
old_pc  out  XLEN  PC of the instruction in execution (registered)
pc_plus_4  out  XLEN  pc+4, combinational
pc_next  out  XLEN  selected candidate, combinational, before the alignment check
redirect  out  1  one-cycle pulse: the last update was non-sequential
exc_pending  out  1  misaligned-target fault awaiting acknowledge
exc_tval  out  XLEN  faulting target address, latched on a fault

Behaviour:
- Reset (rst=1 at a clock edge): pc=RESET_VECTOR, old_pc=RESET_VECTOR, redirect=0, exc_pending=0, exc_tval=0, FSM=RUN. Reset overrides every other input, including in the middle of a pending exception.
- Candidate selection (combinational):
  - 000: pc+4.
  - 001: branch_target if branch_taken=1, else pc+4.
  - 010: branch_target.
  - 011: {alu_output[XLEN-1:1],1'b0}.
  - 100: TRAP_VECTOR.
  - 101: epc_in.
  - 110/111: pc+4.
- All additions wrap modulo 2^XLEN with no overflow flag. Example: pc=FFFF_FFFC gives pc+4=0000_0000.
- Misaligned target: an update is misaligned when the candidate is non-sequential (pcsrc 001-taken, 010, 011 or 101) and either:
  - IALIGN=32 and pc_next[1]=1, or
  - IALIGN=16 and pc_next[0]=1 (cannot occur for jalr).
  - Sequential updates and pcsrc=100 are never misaligned.
- FSM state RUN, on pc_write=1:
  - Aligned update: pc<=pc_next, old_pc<=pc.
  - Misaligned update: pc<=TRAP_VECTOR, old_pc<=pc, exc_tval<=pc_next, exc_pending<=1, then go to TRAPPED.
- FSM state TRAPPED:
  - pc_write is ignored unless pcsrc=100; in that case pc<=TRAP_VECTOR and old_pc<=pc.
  - exc_ack=1 clears exc_pending on the same edge and returns the FSM to RUN.
  - Any pc_write that arrives together with exc_ack is still evaluated under TRAPPED rules.
  - exc_tval holds its value until the next fault.
- pc_write=0 in either state: pc and old_pc hold.
- redirect is 1 in the cycle after any pc_write update whose loaded value differs from the old pc+4 (a taken branch, jal, jalr, trap, return or fault); otherwise it is 0.
- exc_ack while in RUN: no effect.
- Parameter check: if IALIGN is not 16 or 32, or TRAP_VECTOR violates IALIGN, the block must stop elaboration or simulation with an error.
- Latency: pc, old_pc and status outputs update one cycle after the pc_write edge. pc_next and pc_plus_4 have zero latency.

Test Plan:
- Reset then sequential run: rst for 2 cycles, then pc_write=1 with pcsrc=000 for 3 cycles -> pc 0,4,8,C; old_pc 0,0,4,8; redirect=0 throughout.
- Branch: pc=0x10, pcsrc=001, branch_target=0x40. With taken=0 -> pc=0x14, redirect=0. Repeat from pc=0x10 with taken=1 -> pc=0x40, old_pc=0x10, redirect pulses once.
- JALR LSB clear: alu_output=0x0000_0105 -> pc=0x104, no exception. With alu_output=0x0000_0106 and IALIGN=32 -> pc=0x100, exc_pending=1, exc_tval=0x106, FSM=TRAPPED.
- TRAPPED hold: after the fault, pc_write=1 with pcsrc=000 -> pc stays 0x100. Assert exc_ack -> exc_pending=0 next cycle; the following sequential write gives pc=0x104.
- Return and wrap: pcsrc=101 with epc_in=0x0000_0200 -> pc=0x200. Set pc=FFFF_FFFC and do a sequential write -> pc=0, redirect=0.
- Reset mid-trap: with exc_pending=1, assert rst -> pc=RESET_VECTOR, exc_pending=0, exc_tval=0, FSM=RUN. With IALIGN=16, jal to 0x102 -> no fault.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : PC / OLD_PC owner with next-PC selection and
//                misaligned-target trapping for the RV32I multicycle core.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
    parameter int               IALIGN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic [2:0]      pcsrc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] alu_output,
    input  logic [XLEN-1:0] epc_in,
    input  logic            exc_ack,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic [XLEN-1:0] pc_next,
    output logic            redirect,
    output logic            exc_pending,
    output logic [XLEN-1:0] exc_tval
);

    localparam logic [2:0] c_SRC_SEQ    = 3'b000;
    localparam logic [2:0] c_SRC_BRANCH = 3'b001;
    localparam logic [2:0] c_SRC_JAL    = 3'b010;
    localparam logic [2:0] c_SRC_JALR   = 3'b011;
    localparam logic [2:0] c_SRC_TRAP   = 3'b100;
    localparam logic [2:0] c_SRC_RET    = 3'b101;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_TRAPPED = 1'b1
    } state_t;

    state_t          r_state;
    logic            w_nonseq;
    logic            w_misaligned;
    logic [XLEN-1:0] w_load;

    // Elaboration stops on an unsupported alignment or a trap vector that would itself fault.
    if ((IALIGN != 16 && IALIGN != 32) ||
        (IALIGN == 32 && TRAP_VECTOR[1:0] != 2'b00) ||
        TRAP_VECTOR[0]) begin : g_bad_params
        $error("pc_sequencer: illegal IALIGN or misaligned TRAP_VECTOR");
    end

    assign pc_plus_4 = pc + {{(XLEN-3){1'b0}}, 3'd4};

    always_comb begin
        pc_next  = pc_plus_4;
        w_nonseq = 1'b0;
        case (pcsrc)
            c_SRC_SEQ: pc_next = pc_plus_4;
            c_SRC_BRANCH: begin
                pc_next  = branch_taken ? branch_target : pc_plus_4;
                w_nonseq = branch_taken;
            end
            c_SRC_JAL: begin
                pc_next  = branch_target;
                w_nonseq = 1'b1;
            end
            c_SRC_JALR: begin
                pc_next  = {alu_output[XLEN-1:1], 1'b0};
                w_nonseq = 1'b1;
            end
            c_SRC_TRAP: pc_next = TRAP_VECTOR;
            c_SRC_RET: begin
                pc_next  = epc_in;
                w_nonseq = 1'b1;
            end
            default: pc_next = pc_plus_4;
        endcase
    end

    assign w_misaligned = w_nonseq && ((IALIGN == 32) ? pc_next[1] : pc_next[0]);
    assign w_load       = w_misaligned ? TRAP_VECTOR : pc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            old_pc      <= RESET_VECTOR;
            redirect    <= 1'b0;
            exc_pending <= 1'b0;
            exc_tval    <= '0;
            r_state     <= ST_RUN;
        end else begin
            redirect <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (pc_write) begin
                        pc       <= w_load;
                        old_pc   <= pc;
                        redirect <= (w_load != pc_plus_4);
                        if (w_misaligned) begin
                            exc_tval    <= pc_next;
                            exc_pending <= 1'b1;
                            r_state     <= ST_TRAPPED;
                        end
                    end
                end
                ST_TRAPPED: begin
                    // Only a trap-vector write may move the PC while a fault is outstanding.
                    if (pc_write && pcsrc == c_SRC_TRAP) begin
                        pc       <= TRAP_VECTOR;
                        old_pc   <= pc;
                        redirect <= (TRAP_VECTOR != pc_plus_4);
                    end
                    if (exc_ack) begin
                        exc_pending <= 1'b0;
                        r_state     <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    logic w_unused_bits;
    assign w_unused_bits = alu_output[0];

endmodule

`default_nettype wire
